id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register: sits directly downstream of the register file and captures its two combinational read ports plus decoded instruction fields and control.
- Closes the register file's same-cycle write/read window with a writeback bypass.
- Forces register 0 to read as zero.
- Detects load-use hazards, holds the upstream stages with a stall, and inserts a bubble into EX.
- Accepts a flush from branch resolution.

Parameters:
- DATA_W, 32, operand and immediate width.
- PERF_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs  in  5  source register 1 index, also the register-file read address 1.
- id_rt  in  5  source register 2 index, also the register-file read address 2.
- id_rd  in  5  R-type destination index.
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, beq).
- id_imm  in  DATA_W  sign-extended immediate.
- id_ctrl  in  12  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, jump, alu_op[3:0]}.
- rf_rd1  in  DATA_W  register file read port 1 data.
- rf_rd2  in  DATA_W  register file read port 2 data.
- wb_we  in  1  writeback write enable, same signal as the register file write.
- wb_addr  in  5  writeback destination.
- wb_data  in  DATA_W  writeback data.
- flush  in  1  branch or jump taken in EX; squash the ID instruction.
- stall_out  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  EX slot valid.
- ex_ctrl  out  12  registered control.
- ex_op1  out  DATA_W  registered operand 1.
- ex_op2  out  DATA_W  registered operand 2.
- ex_imm  out  DATA_W  registered immediate.
- ex_rs  out  5  registered rs.
- ex_rt  out  5  registered rt.
- ex_rd  out  5  registered rd.
- bubble_cnt  out  PERF_W  count of inserted stall bubbles.

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs are 0, bubble_cnt is 0, ex_valid is 0. stall_out is 0 while reset is asserted. Reset mid-stall discards the held state; the first edge after release loads normally.
- Operand select, per source, combinational:
  - index == 0 gives 0.
  - Otherwise, wb_we && wb_addr == index gives wb_data.
  - Otherwise the value is rf_rdN.
  - op1 uses id_rs; op2 uses id_rt.
- Hazard: hz = ex_valid && ex_ctrl.mem_read && ex_rt != 0 && id_valid && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- stall_out = hz && !flush.
- Rising-edge update, in priority order:
  1. flush: ex_valid = 0, ex_ctrl = 0; data fields don't-care (implementation clears them). bubble_cnt is unchanged.
  2. hz: bubble. ex_valid = 0, ex_ctrl = 0. bubble_cnt increments, saturating at all-ones.
  3. Otherwise: load. ex_valid = id_valid; ex_ctrl = id_valid ? id_ctrl : 0; ex_op1 and ex_op2 get the selected operands; ex_imm, ex_rs, ex_rt and ex_rd get the id_* values.
- Latency: one cycle from ID inputs to ex_* outputs.
- A load-use hazard produces exactly one bubble. The following cycle ex_valid = 0, so hz clears; the held ID instruction then loads, and the loaded value reaches it via EX/MEM forwarding, which is outside this block.
- A bubble's ex_ctrl must be all zero, so no reg_write or mem_write leaks downstream.
- Bypass applies only to the value captured into EX. Later WB writes to an already-captured register are EX forwarding's concern.
- flush and hz in the same cycle: flush wins, stall_out = 0, bubble_cnt unchanged.

Test Plan:
- Bypass: rf_rd1 = 0x11111111, id_rs = 5, wb_we = 1, wb_addr = 5, wb_data = 0xDEADBEEF, then edge → ex_op1 = 0xDEADBEEF. Repeat with wb_addr = 6 → ex_op1 = 0x11111111.
- Zero register: id_rt = 0, rf_rd2 = 0xFFFFFFFF, wb_we = 1, wb_addr = 0 → ex_op2 = 0.
- Load-use: EX holds lw with rt = 8; ID holds add with rs = 8 → stall_out = 1. Next edge: ex_valid = 0, ex_ctrl = 0, bubble_cnt = 1. Following edge: add loads with ex_valid = 1 and stall_out = 0. Same case with id_rt = 8 and id_uses_rt = 0 → no stall.
- Flush priority: flush = 1 together with hazard → stall_out = 0. After the edge, ex_valid = 0 and bubble_cnt unchanged.
- Reset mid-stall: drop rst_n between edges while stall_out = 1 → ex_valid and bubble_cnt go to 0 immediately, without a clock edge.
- Saturation (PERF_W = 2): force 5 consecutive load-use bubbles → bubble_cnt = 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, r0 forcing, load-use bubble and flush; 1-cycle latency.
// Backpressure: stall_out holds PC and IF/ID for one cycle while EX gets a bubble.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [11:0]       id_ctrl,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [11:0]       ex_ctrl,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [PERF_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t             ex_ctrl_q;
  ctrl_t             id_ctrl_s;
  logic [DATA_W-1:0] op1_sel;
  logic [DATA_W-1:0] op2_sel;
  logic              hz;

  assign id_ctrl_s = ctrl_t'(id_ctrl);
  assign ex_ctrl   = ex_ctrl_q;

  // Register file writes land at the same edge we capture, so bypass WB data here.
  always_comb begin
    op1_sel = rf_rd1;
    if (id_rs == 5'd0)
      op1_sel = '0;
    else if (wb_we && (wb_addr == id_rs))
      op1_sel = wb_data;

    op2_sel = rf_rd2;
    if (id_rt == 5'd0)
      op2_sel = '0;
    else if (wb_we && (wb_addr == id_rt))
      op2_sel = wb_data;
  end

  assign hz = ex_valid && ex_ctrl_q.mem_read && (ex_rt != 5'd0) && id_valid &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign stall_out = hz && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      bubble_cnt <= '0;
    end else if (flush || hz) begin
      // Squash and bubble share the cleared payload; only a bubble is counted.
      ex_valid  <= 1'b0;
      ex_ctrl_q <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      if (!flush && (bubble_cnt != {PERF_W{1'b1}}))
        bubble_cnt <= bubble_cnt + PERF_W'(1);
    end else begin
      ex_valid  <= id_valid;
      ex_ctrl_q <= id_valid ? id_ctrl_s : ctrl_t'('0);
      ex_op1    <= op1_sel;
      ex_op2    <= op2_sel;
      ex_imm    <= id_imm;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
    end
  end

endmodule
